// File: rtl/uart_alu_intf_pkg.sv
// Shared definitions for the UART-fed ALU: widths, opcodes and FSM encoding.
package uart_alu_intf_pkg;

  localparam int unsigned DBIT_DEF  = 8;
  localparam int unsigned NB_OP_DEF = 6;

  // Opcodes, taken from the low NB_OP bits of the received opcode byte
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_CALC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  // True in the states that consume a byte from the RX FIFO
  function automatic logic is_get_state(input state_t s);
    return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_intf_alu.sv
// Combinational ALU: eight operations, flags unsupported opcodes.
module uart_alu_intf_alu
  import uart_alu_intf_pkg::*;
#(
  parameter int unsigned DBIT  = DBIT_DEF,
  parameter int unsigned NB_OP = NB_OP_DEF
) (
  input  logic [DBIT-1:0]  a,
  input  logic [DBIT-1:0]  b,
  input  logic [NB_OP-1:0] op,
  output logic [DBIT-1:0]  result,
  output logic             invalid
);

  // Operation decode; shifts by B >= DBIT saturate to sign fill / zero by operator semantics
  always_comb begin
    result  = '0;
    invalid = 1'b0;
    case (op)
      NB_OP'(OP_ADD): result = a + b;
      NB_OP'(OP_SUB): result = a - b;
      NB_OP'(OP_AND): result = a & b;
      NB_OP'(OP_OR):  result = a | b;
      NB_OP'(OP_XOR): result = a ^ b;
      NB_OP'(OP_NOR): result = ~(a | b);
      NB_OP'(OP_SRA): result = $signed(a) >>> b;
      NB_OP'(OP_SRL): result = a >> b;
      default: begin
        result  = '0;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_alu_intf.sv
// Glue between a UART RX/TX FIFO pair and the ALU: pops A, B, OP, computes, pushes result.
module uart_alu_intf
  import uart_alu_intf_pkg::*;
#(
  parameter int unsigned DBIT  = DBIT_DEF,
  parameter int unsigned NB_OP = NB_OP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] r_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic            op_error,
  output logic            busy
);

  state_t            state;
  state_t            state_next;
  logic              rd_q;
  logic              busy_q;
  logic              pop_ok;
  logic              ld_a;
  logic              ld_b;
  logic              ld_op;
  logic              ld_res;
  logic [DBIT-1:0]   a_q;
  logic [DBIT-1:0]   b_q;
  logic [NB_OP-1:0]  op_q;
  logic [DBIT-1:0]  result_q;
  logic             op_error_q;
  logic [DBIT-1:0]  alu_result;
  logic             alu_invalid;

  // A pop is allowed out of reset, with data present, and never right after another pop
  assign pop_ok = reset & ~rx_empty & ~rd_q & is_get_state(state);

  // State register, pop history and registered busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_GET_A;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      rd_q   <= rd_uart;
      busy_q <= (state_next != ST_GET_A);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_GET_A:  if (pop_ok) state_next = ST_GET_B;
      ST_GET_B:  if (pop_ok) state_next = ST_GET_OP;
      ST_GET_OP: if (pop_ok) state_next = ST_CALC;
      ST_CALC:   state_next = ST_SEND;
      ST_SEND:   if (!tx_full) state_next = ST_GET_A;
      default:   state_next = ST_GET_A;
    endcase
  end

  // FIFO handshakes and register load enables
  always_comb begin
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    case (state)
      ST_GET_A: begin
        rd_uart = pop_ok;
        ld_a    = pop_ok;
      end
      ST_GET_B: begin
        rd_uart = pop_ok;
        ld_b    = pop_ok;
      end
      ST_GET_OP: begin
        rd_uart = pop_ok;
        ld_op   = pop_ok;
      end
      ST_CALC:  ld_res  = 1'b1;
      ST_SEND:  wr_uart = ~tx_full;
      default: ;
    endcase
  end

  // Operand, opcode and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      op_error_q <= 1'b0;
    end else begin
      if (ld_a)  a_q  <= r_data;
      if (ld_b)  b_q  <= r_data;
      if (ld_op) op_q <= r_data[NB_OP-1:0];
      if (ld_res) begin
        result_q   <= alu_result;
        op_error_q <= alu_invalid;
      end
    end
  end

  uart_alu_intf_alu #(
    .DBIT  (DBIT),
    .NB_OP (NB_OP)
  ) u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .result  (alu_result),
    .invalid (alu_invalid)
  );

  assign w_data   = result_q;
  assign op_error = op_error_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Scoreboard bench: RX FIFO model feeds bytes, monitor checks every TX push.
module tb_uart_alu_intf;

  logic       clk;
  logic       reset;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       op_error;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] rxq[$];

  int errors    = 0;
  int checks    = 0;
  int pop_count = 0;
  int pushed    = 0;
  int wr_count  = 0;
  logic rd_seen = 1'b0;
  logic rd_prev = 1'b0;
  logic gap_mode = 1'b0;

  uart_alu_intf #(
    .DBIT  (8),
    .NB_OP (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .op_error (op_error),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // RX FIFO model: pops the head when the DUT popped at this edge, then presents the next head
  always @(posedge clk) begin
    #1;
    if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
    rx_empty = (rxq.size() == 0) || (gap_mode && ($urandom_range(0, 1) == 1));
    r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // Monitor: pop-protocol checks and scoreboard comparison of each TX push
  always @(negedge clk) begin
    rd_seen = rd_uart;
    if (reset) begin
      if (rd_uart) begin
        pop_count++;
        chk("rd_while_empty", 32'(rx_empty), 32'd0);
        chk("rd_back_to_back", 32'(rd_prev), 32'd0);
        chk("rd_wr_overlap", 32'(wr_uart), 32'd0);
      end
      if (wr_uart) begin
        wr_count++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got w_data %0h required no push", w_data);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("w_data", 32'(w_data), 32'(e.data));
          chk("op_error", 32'(op_error), 32'(e.err));
        end
      end
    end
    rd_prev = rd_uart;
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] res, input logic err);
    exp_t e;
    e.data = res;
    e.err  = err;
    expq.push_back(e);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    pushed += 3;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && rxq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout with %0d results pending, required 0", name, expq.size());
    end
  endtask

  task automatic wait_pops(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pop_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: pops %0d required %0d", name, pop_count, target);
    end
  endtask

  // Global time bound
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    reset    = 1'b0;
    tx_full  = 1'b0;
    rx_empty = 1'b1;
    r_data   = 8'h00;

    // Reset state, with bytes already waiting in the FIFO
    run_op(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_rd_uart", 32'(rd_uart), 32'd0);
    chk("reset_wr_uart", 32'(wr_uart), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_w_data", 32'(w_data), 32'd0);
    chk("reset_op_error", 32'(op_error), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    wait_done("add_basic");

    // Main operations
    run_op(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    run_op(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
    run_op(8'h80, 8'h02, 8'h02, 8'h20, 1'b0);
    run_op(8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0);
    run_op(8'hF0, 8'h0F, 8'h25, 8'hFF, 1'b0);
    run_op(8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0);
    run_op(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0);
    run_op(8'hFF, 8'h02, 8'h20, 8'h01, 1'b0);
    run_op(8'h80, 8'h09, 8'h03, 8'hFF, 1'b0);
    run_op(8'hFF, 8'h08, 8'h02, 8'h00, 1'b0);
    run_op(8'h40, 8'h01, 8'h03, 8'h20, 1'b0);
    run_op(8'h01, 8'h01, 8'hE0, 8'h02, 1'b0);
    wait_done("alu_ops");

    // Unsupported opcode, flag holds, then cleared by a valid op
    run_op(8'h12, 8'h34, 8'h3F, 8'h00, 1'b1);
    wait_done("invalid_op");
    repeat (2) @(negedge clk);
    chk("op_error_hold", 32'(op_error), 32'd1);
    run_op(8'h10, 8'h20, 8'h20, 8'h30, 1'b0);
    wait_done("clear_error");
    chk("op_error_cleared", 32'(op_error), 32'd0);

    // TX backpressure held in SEND
    @(posedge clk); #2;
    tx_full = 1'b1;
    run_op(8'h0A, 8'h05, 8'h26, 8'h0F, 1'b0);
    wait_pops(pushed, "backpressure_pops");
    repeat (3) @(negedge clk);
    wc = wr_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_no_wr", 32'(wr_uart), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #2;
    tx_full = 1'b0;
    wait_done("backpressure_release");
    chk("full_single_push", 32'(wr_count - wc), 32'd1);

    // Reset mid-sequence after A and B popped, with op_error and result set beforehand
    run_op(8'h00, 8'h00, 8'h3F, 8'h00, 1'b1);
    wait_done("invalid_before_reset");
    run_op(8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
    wait_done("result_before_reset");
    run_op(8'h12, 8'h34, 8'h3F, 8'h00, 1'b1);
    wait_done("flag_before_reset");
    rxq.push_back(8'h07);
    rxq.push_back(8'h01);
    pushed += 2;
    wait_pops(pushed, "partial_pops");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_op_error", 32'(op_error), 32'd0);
    chk("midreset_rd_uart", 32'(rd_uart), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    run_op(8'h02, 8'h02, 8'h20, 8'h04, 1'b0);
    wait_done("after_reset");

    // Random gaps in RX FIFO availability
    gap_mode = 1'b1;
    run_op(8'h11, 8'h22, 8'h20, 8'h33, 1'b0);
    run_op(8'h00, 8'h01, 8'h22, 8'hFF, 1'b0);
    run_op(8'h0C, 8'h03, 8'h25, 8'h0F, 1'b0);
    wait_done("gap_ops");
    gap_mode = 1'b0;

    repeat (3) @(negedge clk);
    chk("total_pops", 32'(pop_count), 32'(pushed));
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
